// File: rtl/lc2k_pkg.sv
// ============================================================================
// lc2k_pkg
// Shared LC2K register-file constants and types.
// Revision: 1.0
// ============================================================================
`default_nettype none

package lc2k_pkg;

  localparam int DATA_W   = 32;
  localparam int NUM_REGS = 8;
  localparam int ADDR_W   = 3;

  typedef logic [ADDR_W-1:0] reg_idx_t;
  typedef logic [DATA_W-1:0] word_t;

endpackage

`default_nettype wire

// File: rtl/lc2k_scoreboard.sv
// ============================================================================
// lc2k_scoreboard
// Per-register busy bits for in-flight writes, with per-port busy lookup.
// Revision: 1.0
// ============================================================================
`default_nettype none

module lc2k_scoreboard
  import lc2k_pkg::*;
#(
  parameter int NUM_REGS = lc2k_pkg::NUM_REGS,
  parameter int ADDR_W   = lc2k_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              claim_en,
  input  logic [ADDR_W-1:0] claim_reg,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] write_reg,
  input  logic [ADDR_W-1:0] regA,
  input  logic [ADDR_W-1:0] regB,
  output logic              busy_a,
  output logic              busy_b
);

  logic [NUM_REGS-1:0] r_busy;
  logic [NUM_REGS-1:0] w_busy_nxt;

  // Clear before set, so a claim on the same edge as the write-back wins:
  // the claim belongs to the younger instruction.
  always_comb begin
    w_busy_nxt = r_busy;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (wr_en && (write_reg == ADDR_W'(i))) begin
        w_busy_nxt[i] = 1'b0;
      end
      if (claim_en && (claim_reg == ADDR_W'(i))) begin
        w_busy_nxt[i] = 1'b1;
      end
    end
    w_busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy <= '0;
    end else begin
      r_busy <= w_busy_nxt;
    end
  end

  assign busy_a = r_busy[regA];
  assign busy_b = r_busy[regB];

endmodule

`default_nettype wire

// File: rtl/lc2k_reg_file.sv
// ============================================================================
// lc2k_reg_file
// LC2K architectural register file: one write port, two registered read
// ports, busy-scoreboard hazard stall. Optional same-cycle write-to-read
// forwarding is enabled by defining LC2K_REG_FILE_BYPASS_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module lc2k_reg_file
  import lc2k_pkg::*;
#(
  parameter int DATA_W   = lc2k_pkg::DATA_W,
  parameter int NUM_REGS = lc2k_pkg::NUM_REGS,
  parameter int ADDR_W   = lc2k_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] regA,
  input  logic [ADDR_W-1:0] regB,
  output logic              rd_valid,
  output logic [DATA_W-1:0] regA_val,
  output logic [DATA_W-1:0] regB_val,
  output logic              stall,
  input  logic              claim_en,
  input  logic [ADDR_W-1:0] claim_reg,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] write_reg,
  input  logic [DATA_W-1:0] write_data
);

  logic [DATA_W-1:0] r_regs [NUM_REGS];
  logic              r_rd_valid;
  logic [DATA_W-1:0] r_regA_val;
  logic [DATA_W-1:0] r_regB_val;

  logic              w_busy_a;
  logic              w_busy_b;
  logic              w_busy_a_eff;
  logic              w_busy_b_eff;
  logic [DATA_W-1:0] w_val_a;
  logic [DATA_W-1:0] w_val_b;
  logic              w_accept;

  lc2k_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .ADDR_W   (ADDR_W)
  ) u_scoreboard (
    .clk       (clk),
    .rst       (rst),
    .claim_en  (claim_en),
    .claim_reg (claim_reg),
    .wr_en     (wr_en),
    .write_reg (write_reg),
    .regA      (regA),
    .regB      (regB),
    .busy_a    (w_busy_a),
    .busy_b    (w_busy_b)
  );

  // Register 0 is never written, so it stays at its reset value of zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (wr_en && (write_reg != '0)) begin
      r_regs[write_reg] <= write_data;
    end
  end

`ifdef LC2K_REG_FILE_BYPASS_EN
  logic w_fwd_a;
  logic w_fwd_b;
  logic w_reclaim_a;
  logic w_reclaim_b;

  assign w_fwd_a     = wr_en && (write_reg == regA) && (regA != '0);
  assign w_fwd_b     = wr_en && (write_reg == regB) && (regB != '0);
  assign w_reclaim_a = claim_en && (claim_reg == regA);
  assign w_reclaim_b = claim_en && (claim_reg == regB);

  // A write-back landing this cycle satisfies the hazard, unless a younger
  // instruction re-claims the same register on the same edge.
  assign w_busy_a_eff = w_busy_a && !(w_fwd_a && !w_reclaim_a);
  assign w_busy_b_eff = w_busy_b && !(w_fwd_b && !w_reclaim_b);
  assign w_val_a      = w_fwd_a ? write_data : r_regs[regA];
  assign w_val_b      = w_fwd_b ? write_data : r_regs[regB];
`else
  assign w_busy_a_eff = w_busy_a;
  assign w_busy_b_eff = w_busy_b;
  assign w_val_a      = r_regs[regA];
  assign w_val_b      = r_regs[regB];
`endif

  assign stall    = rd_en && (w_busy_a_eff || w_busy_b_eff);
  assign w_accept = rd_en && !stall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_valid <= 1'b0;
      r_regA_val <= '0;
      r_regB_val <= '0;
    end else begin
      r_rd_valid <= w_accept;
      if (w_accept) begin
        r_regA_val <= w_val_a;
        r_regB_val <= w_val_b;
      end
    end
  end

  assign rd_valid = r_rd_valid;
  assign regA_val = r_regA_val;
  assign regB_val = r_regB_val;

endmodule

`default_nettype wire

// File: tb/tb_lc2k_reg_file.sv
// ============================================================================
// tb_lc2k_reg_file
// Scoreboard bench for lc2k_reg_file against an array-based register model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_lc2k_reg_file;

  localparam int DW = 32;
  localparam int NR = 8;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          rd_en;
  logic [AW-1:0] regA;
  logic [AW-1:0] regB;
  logic          rd_valid;
  logic [DW-1:0] regA_val;
  logic [DW-1:0] regB_val;
  logic          stall;
  logic          claim_en;
  logic [AW-1:0] claim_reg;
  logic          wr_en;
  logic [AW-1:0] write_reg;
  logic [DW-1:0] write_data;

  lc2k_reg_file dut (
    .clk        (clk),
    .rst        (rst),
    .rd_en      (rd_en),
    .regA       (regA),
    .regB       (regB),
    .rd_valid   (rd_valid),
    .regA_val   (regA_val),
    .regB_val   (regB_val),
    .stall      (stall),
    .claim_en   (claim_en),
    .claim_reg  (claim_reg),
    .wr_en      (wr_en),
    .write_reg  (write_reg),
    .write_data (write_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            due;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
  } exp_t;

  exp_t          q[$];
  int            vectors     = 0;
  int            miscompares = 0;
  int            cyc         = 0;
  logic [DW-1:0] m_regs [NR];
  bit            m_busy [NR];
  logic [DW-1:0] last_a = '0;
  logic [DW-1:0] last_b = '0;

  always @(posedge clk) cyc = cyc + 1;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model: busy seen by decode for one read index, given the current inputs.
  function automatic bit eff_busy(input logic [AW-1:0] idx);
    if (idx == 0) return 1'b0;
`ifdef LC2K_REG_FILE_BYPASS_EN
    if (wr_en && write_reg == idx && !(claim_en && claim_reg == idx)) return 1'b0;
`endif
    return m_busy[idx];
  endfunction

  function automatic logic [DW-1:0] exp_val(input logic [AW-1:0] idx);
    if (idx == 0) return '0;
`ifdef LC2K_REG_FILE_BYPASS_EN
    if (wr_en && write_reg == idx) return write_data;
`endif
    return m_regs[idx];
  endfunction

  task automatic model_clear();
    for (int i = 0; i < NR; i++) begin
      m_regs[i] = '0;
      m_busy[i] = 1'b0;
    end
  endtask

  // One cycle of stimulus; entered and left at posedge+1.
  task automatic step(input bit re, input int a, input int b,
                      input bit ce, input int cr,
                      input bit we, input int wr, input logic [DW-1:0] wd);
    bit exp_stall;
    rd_en      = re;
    regA       = AW'(a);
    regB       = AW'(b);
    claim_en   = ce;
    claim_reg  = AW'(cr);
    wr_en      = we;
    write_reg  = AW'(wr);
    write_data = wd;
    @(negedge clk);
    exp_stall = re && (eff_busy(regA) || eff_busy(regB));
    check("stall", {31'b0, stall}, {31'b0, exp_stall});
    if (re && !exp_stall) begin
      q.push_back('{due: cyc + 1, a: exp_val(regA), b: exp_val(regB)});
    end
    if (we) begin
      if (write_reg != 0) m_regs[write_reg] = wd;
      m_busy[write_reg] = 1'b0;
    end
    if (ce && claim_reg != 0) m_busy[claim_reg] = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Asynchronous reset in the middle of a cycle, keeping current inputs.
  task automatic mid_reset();
    rst = 1'b1;
    #1;
    check("rst_stall", {31'b0, stall}, '0);
    check("rst_valid", {31'b0, rd_valid}, '0);
    check("rst_a", regA_val, '0);
    check("rst_b", regB_val, '0);
    model_clear();
    q.delete();
    last_a = '0;
    last_b = '0;
    rd_en    = 1'b0;
    claim_en = 1'b0;
    wr_en    = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // Monitor: pops an expectation whenever the DUT presents read data.
  always @(negedge clk) begin
    exp_t e;
    if (rd_valid) begin
      if (q.size() == 0) begin
        check("rd_valid_spurious", 32'd1, 32'd0);
      end else begin
        e = q.pop_front();
        check("rd_latency", 32'(cyc), 32'(e.due));
        check("regA_val", regA_val, e.a);
        check("regB_val", regB_val, e.b);
        last_a = e.a;
        last_b = e.b;
      end
    end else if (q.size() > 0 && q[0].due <= cyc) begin
      check("rd_valid_missing", 32'd0, 32'd1);
      void'(q.pop_front());
    end
    check("hold_a", regA_val, last_a);
    check("hold_b", regB_val, last_b);
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    model_clear();
    rst = 1'b1;
    rd_en = 1'b0; regA = '0; regB = '0;
    claim_en = 1'b0; claim_reg = '0;
    wr_en = 1'b0; write_reg = '0; write_data = '0;
    #1;
    check("por_valid", {31'b0, rd_valid}, '0);
    check("por_stall", {31'b0, stall}, '0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Directed sequence.
    step(1, 3, 5, 0, 0, 0, 0, '0);
    step(0, 0, 0, 0, 0, 1, 2, 32'h1234);
    step(1, 2, 0, 0, 0, 0, 0, '0);
    step(0, 0, 0, 0, 0, 1, 0, 32'hFFFF);
    step(1, 0, 0, 0, 0, 0, 0, '0);
    step(0, 0, 0, 1, 0, 0, 0, '0);
    step(1, 0, 0, 0, 0, 0, 0, '0);
    step(0, 0, 0, 1, 4, 0, 0, '0);
    step(1, 0, 4, 0, 0, 0, 0, '0);
    step(1, 0, 4, 0, 0, 1, 4, 32'd7);
    step(1, 0, 4, 0, 0, 0, 0, '0);
    step(0, 0, 0, 1, 6, 1, 6, 32'h66);
    step(1, 6, 0, 0, 0, 0, 0, '0);
    step(0, 0, 0, 0, 0, 1, 1, 32'hABC);
    step(1, 6, 1, 0, 0, 0, 0, '0);
    mid_reset();
    step(1, 1, 2, 0, 0, 0, 0, '0);
    step(0, 0, 0, 0, 0, 0, 0, '0);

    // Randomized traffic with occasional resets.
    for (int n = 0; n < 2000; n++) begin
      step($urandom_range(0, 1), $urandom_range(0, NR - 1), $urandom_range(0, NR - 1),
           ($urandom_range(0, 3) == 0), $urandom_range(0, NR - 1),
           $urandom_range(0, 1), $urandom_range(0, NR - 1), $urandom);
      if (n % 500 == 499) mid_reset();
    end

    repeat (3) step(0, 0, 0, 0, 0, 0, 0, '0);
    check("queue_drain", 32'(q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/lc2k_reg_file.md
# lc2k_reg_file

Architectural register file for the LC2K CPU, and the consumer of the selected write-register index. Provides one write port, driven by the write-back stage's `write_reg`/data, and two registered read ports, driven by the decode stage's regA/regB. A per-register busy scoreboard lets decode detect read-after-write hazards against in-flight writes and stall instead of reading stale data.

## Interface
Parameters:
- `DATA_W`, 32, register width in bits
- `NUM_REGS`, 8, number of architectural registers
- `ADDR_W`, 3, register index width; clog2(NUM_REGS)

Ports:
- `clk`  in  1  clock; all state updates on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `rd_en`  in  1  decode requests a read of regA/regB this cycle
- `regA`  in  ADDR_W  read port A index
- `regB`  in  ADDR_W  read port B index
- `rd_valid`  out  1  registered; regA_val/regB_val are valid this cycle
- `regA_val`  out  DATA_W  registered read data, port A
- `regB_val`  out  DATA_W  registered read data, port B
- `stall`  out  1  combinational; rd_en accepted only when 0
- `claim_en`  in  1  issued instruction will write `claim_reg`
- `claim_reg`  in  ADDR_W  destination being claimed
- `wr_en`  in  1  write-back strobe
- `write_reg`  in  ADDR_W  write-back destination (output of write-register mux)
- `write_data`  in  DATA_W  write-back value

## Operation
- Storage: NUM_REGS x DATA_W flops. Register 0 reads as 0 always; writes and claims to index 0 are ignored.
- Write: `wr_en`=1 and `write_reg`≠0 → regs[write_reg] ← write_data at the rising edge.
- Scoreboard: busy[NUM_REGS], one bit per register.
  - Set at the edge where `claim_en`=1 and `claim_reg`≠0.
  - Cleared at the edge where `wr_en`=1 on that index.
  - Simultaneous claim and write on the same index: bit stays set (the claim belongs to the newer instruction). The data write still occurs.
- Hazard: `stall` = rd_en & (busy[regA] | busy[regB]), with busy of index 0 forced to 0. Bypass modifies this (see Configuration).
- Read accept: rd_en=1 & stall=0 → at the next edge capture regA_val/regB_val and set rd_valid=1. Otherwise rd_valid←0 and the value outputs hold their previous contents.
- Out-of-range indices are impossible, since NUM_REGS = 2^ADDR_W.

## Timing
- Reset (asynchronous): all regs = 0, busy = 0, rd_valid = 0, regA_val = regB_val = 0. `stall` = 0 while in reset.
- Read latency: 1 cycle (rd_en at edge N → data and rd_valid after edge N+1).
- Write latency: data is visible to a read accepted at the edge following the write edge; same-edge visibility depends on the Configuration macro.
- Claim takes effect for `stall` in the cycle after the claim edge.
- Reset asserted mid-operation clears busy and data immediately; rd_valid drops asynchronously.

## Configuration
- `LC2K_REG_FILE_BYPASS_EN` defined: write-to-read forwarding in the same cycle.
  - If wr_en=1 and write_reg matches regA (or regB, nonzero), the captured value is write_data.
  - That port's busy bit is treated as clear for `stall`, unless the same edge also re-claims that index.
- Undefined: no forwarding.
  - Same-cycle write/read of one index stalls if busy; if not busy, the pre-write value is captured.

## Structure
- Shared package `lc2k_pkg`: DATA_W, NUM_REGS, ADDR_W constants; `reg_idx_t` typedef (ADDR_W bits); `word_t` typedef (DATA_W bits).
- One sub-module, `lc2k_scoreboard`: owns the busy bits, claim/clear logic and per-port busy lookup.
- Storage, read capture and bypass live in the top module.

## Test plan
- Reset then rd_en regA=3, regB=5 → stall=0; next cycle rd_valid=1, both values 0.
- wr_en write_reg=2 data=0x1234, next cycle read regA=2 → regA_val=0x1234 one cycle later.
- Write reg0 data=0xFFFF, then read regA=0 → regA_val=0; claim reg0 → no stall.
- claim_reg=4; next cycle rd_en regB=4 → stall=1, rd_valid stays 0. wr_en reg4 data=7 → stall drops (same cycle with bypass; next cycle without), and regB_val=7.
- Same edge claim_en and wr_en both on reg6 → busy[6] remains 1; a read of reg6 stalls.
- Reset asserted mid-stall with busy set → stall=0, rd_valid=0 immediately; read of the previously written reg returns 0.
